// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the ARM core pipeline.
// Tracks destinations of instructions in flight after ID, decides each cycle
// whether ID may advance (freeze/bubble/flush/stall_all), and registers the
// EXE operand forwarding selects. Saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned STAGES = 3,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src1_en,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              branch_taken,
  input  logic              mem_ready,
  output logic              freeze,
  output logic              bubble,
  output logic              flush,
  output logic              stall_all,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The WB slot writes through the write-first register file in the same
  // cycle, so it can never cause a stall or a forward; only 0..STAGES-2 are kept.
  localparam int unsigned NTRK = STAGES - 1;

  typedef struct packed {
    logic              v;
    logic              wb;
    logic [REG_AW-1:0] dest;
  } entry_t;

  entry_t [NTRK-1:0] sb_q, sb_d;
  logic              ld0_q, ld0_d;   // load flag of the EXE entry (load-use check)
  logic [SEL_W-1:0]  fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]  fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [NTRK-1:0]   match_a_c, match_b_c;
  logic              hazard_c;
  logic              advance_c;

  // RAW match of each enabled ID source against every tracked writer
  always_comb begin
    match_a_c = '0;
    match_b_c = '0;
    for (int unsigned i = 0; i < NTRK; i++) begin
      match_a_c[i] = id_valid & id_src1_en & sb_q[i].v & sb_q[i].wb &
                     (sb_q[i].dest == id_src1);
      match_b_c[i] = id_valid & id_two_src & sb_q[i].v & sb_q[i].wb &
                     (sb_q[i].dest == id_src2);
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Everything forwards except a load still in EXE
      assign hazard_c = (match_a_c[0] | match_b_c[0]) & ld0_q;
    end else begin : g_nofwd
      // Without forwarding any pending writer blocks ID
      assign hazard_c = |(match_a_c | match_b_c);
    end
  endgenerate

  // Per-cycle control decision: memory wait, then branch, then hazard
  always_comb begin
    stall_all = ~mem_ready;
    freeze    = ~mem_ready;
    flush     = 1'b0;
    bubble    = 1'b0;
    advance_c = 1'b0;
    if (mem_ready) begin
      if (branch_taken) begin
        flush = 1'b1;
      end else if (hazard_c) begin
        freeze = 1'b1;
        bubble = 1'b1;
      end else begin
        advance_c = 1'b1;
      end
    end
  end

  // Next state: shift scoreboard, choose forward selects, bump counters
  always_comb begin
    sb_d        = sb_q;
    ld0_d       = ld0_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_ready) begin
      for (int unsigned i = NTRK - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      fwd_a_d = '0;
      fwd_b_d = '0;
      if (advance_c) begin
        sb_d[0].v    = id_valid;
        sb_d[0].wb   = id_wb_en;
        sb_d[0].dest = id_dest;
        ld0_d        = id_mem_r_en;
        if (FWD_EN != 0) begin
          // Scan oldest to youngest so the youngest writer wins
          for (int unsigned j = NTRK; j > 0; j--) begin
            if (match_a_c[j-1]) fwd_a_d = SEL_W'(j);
            if (match_b_c[j-1]) fwd_b_d = SEL_W'(j);
          end
        end
      end else begin
        sb_d[0] = '0;
        ld0_d   = 1'b0;
      end
      if (flush && (stall_cnt_q == stall_cnt_q) && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (bubble && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      ld0_q       <= 1'b0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      ld0_q       <= ld0_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: three configurations driven by
// the same ID stream, each checked every cycle against a behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_src1_en = 1'b0, id_two_src = 1'b0;
  logic       id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic       branch_taken = 1'b0, mem_ready = 1'b1;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dest = '0;

  // dut_f: FWD_EN=1 STAGES=3 CNT_W=16 ; dut_n: FWD_EN=0 STAGES=4 CNT_W=4 ;
  // dut_s: FWD_EN=0 STAGES=3 CNT_W=4
  logic        f_fr, f_bu, f_fl, f_sa, n_fr, n_bu, n_fl, n_sa, s_fr, s_bu, s_fl, s_sa;
  logic [1:0]  f_fa, f_fb, n_fa, n_fb, s_fa, s_fb;
  logic [15:0] f_sc, f_fc;
  logic [3:0]  n_sc, n_fc, s_sc, s_fc;

  hazard_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .freeze(f_fr), .bubble(f_bu), .flush(f_fl), .stall_all(f_sa),
    .fwd_sel_a(f_fa), .fwd_sel_b(f_fb), .stall_cnt(f_sc), .flush_cnt(f_fc));

  hazard_scoreboard #(.REG_AW(4), .STAGES(4), .FWD_EN(0), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .freeze(n_fr), .bubble(n_bu), .flush(n_fl), .stall_all(n_sa),
    .fwd_sel_a(n_fa), .fwd_sel_b(n_fb), .stall_cnt(n_sc), .flush_cnt(n_fc));

  hazard_scoreboard #(.REG_AW(4), .STAGES(3), .FWD_EN(0), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .freeze(s_fr), .bubble(s_bu), .flush(s_fl), .stall_all(s_sa),
    .fwd_sel_a(s_fa), .fwd_sel_b(s_fb), .stall_cnt(s_sc), .flush_cnt(s_fc));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: each configuration is an ordered list of in-flight instructions,
  // slot 0 = EXE ... slot STAGES-1 = WB.
  typedef struct {
    bit v;
    bit wb;
    bit ld;
    int dest;
  } rec_t;

  int   cfg_s   [3] = '{3, 4, 3};
  int   cfg_f   [3] = '{1, 0, 0};
  int   cfg_max [3] = '{65535, 15, 15};
  rec_t pipe  [3][8];
  rec_t npipe [3][8];
  int   fa [3], fb [3], sc [3], fc [3];
  int   nfa[3], nfb[3], nsc[3], nfc[3];

  task automatic cmp(input string nm, input int c, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, c, cyc, act, exp);
    end
  endtask

  // True when ID reads a register the instruction in slot i will write
  function automatic bit dep(input int c, input int i, input bit en, input logic [3:0] src);
    return en && id_valid && pipe[c][i].v && pipe[c][i].wb && (pipe[c][i].dest == int'(src));
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        pipe[c][i].v = 0; pipe[c][i].wb = 0; pipe[c][i].ld = 0; pipe[c][i].dest = 0;
        npipe[c][i] = pipe[c][i];
      end
      fa[c] = 0; fb[c] = 0; sc[c] = 0; fc[c] = 0;
      nfa[c] = 0; nfb[c] = 0; nsc[c] = 0; nfc[c] = 0;
    end
  endtask

  task automatic eval_cfg(input int c, input int a_fr, input int a_bu, input int a_fl,
                          input int a_sa, input int a_fa, input int a_fb,
                          input int a_sc, input int a_fc);
    int S;
    bit hz, adv, e_bu, e_fl;
    S  = cfg_s[c];
    hz = 0;
    if (cfg_f[c] != 0) begin
      hz = pipe[c][0].ld && (dep(c, 0, id_src1_en, id_src1) || dep(c, 0, id_two_src, id_src2));
    end else begin
      for (int i = 0; i < S - 1; i++)
        if (dep(c, i, id_src1_en, id_src1) || dep(c, i, id_two_src, id_src2)) hz = 1;
    end
    e_fl = mem_ready && branch_taken;
    e_bu = mem_ready && !branch_taken && hz;
    cmp("stall_all", c, a_sa, int'(!mem_ready));
    cmp("freeze",    c, a_fr, int'(!mem_ready || e_bu));
    cmp("bubble",    c, a_bu, int'(e_bu));
    cmp("flush",     c, a_fl, int'(e_fl));
    cmp("fwd_sel_a", c, a_fa, fa[c]);
    cmp("fwd_sel_b", c, a_fb, fb[c]);
    cmp("stall_cnt", c, a_sc, sc[c]);
    cmp("flush_cnt", c, a_fc, fc[c]);
    // Next model state
    for (int i = 0; i < 8; i++) npipe[c][i] = pipe[c][i];
    nfa[c] = fa[c]; nfb[c] = fb[c]; nsc[c] = sc[c]; nfc[c] = fc[c];
    if (mem_ready) begin
      for (int i = S - 1; i > 0; i--) npipe[c][i] = pipe[c][i-1];
      adv = !branch_taken && !hz;
      npipe[c][0].v    = adv && id_valid;
      npipe[c][0].wb   = adv && id_wb_en;
      npipe[c][0].ld   = adv && id_mem_r_en;
      npipe[c][0].dest = adv ? int'(id_dest) : 0;
      nfa[c] = 0;
      nfb[c] = 0;
      if (adv && cfg_f[c] != 0) begin
        for (int j = 0; j <= S - 2; j++) begin
          if (nfa[c] == 0 && dep(c, j, id_src1_en, id_src1)) nfa[c] = j + 1;
          if (nfb[c] == 0 && dep(c, j, id_two_src, id_src2)) nfb[c] = j + 1;
        end
      end
      if (e_fl && fc[c] < cfg_max[c]) nfc[c] = fc[c] + 1;
      if (e_bu && sc[c] < cfg_max[c]) nsc[c] = sc[c] + 1;
    end
  endtask

  // Compare process: every cycle, all three DUTs against the model
  always @(negedge clk) begin
    cyc++;
    eval_cfg(0, int'(f_fr), int'(f_bu), int'(f_fl), int'(f_sa), int'(f_fa), int'(f_fb), int'(f_sc), int'(f_fc));
    eval_cfg(1, int'(n_fr), int'(n_bu), int'(n_fl), int'(n_sa), int'(n_fa), int'(n_fb), int'(n_sc), int'(n_fc));
    eval_cfg(2, int'(s_fr), int'(s_bu), int'(s_fl), int'(s_sa), int'(s_fa), int'(s_fb), int'(s_sc), int'(s_fc));
  end

  // Model state advance, cleared asynchronously like the DUT
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < 8; i++) pipe[c][i] = npipe[c][i];
        fa[c] = nfa[c]; fb[c] = nfb[c]; sc[c] = nsc[c]; fc[c] = nfc[c];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit s1e, input int s1, input bit two, input int s2,
                       input bit wb, input bit ld, input int d, input bit br, input bit mr);
    id_valid = v; id_src1_en = s1e; id_src1 = 4'(s1); id_two_src = two; id_src2 = 4'(s2);
    id_wb_en = wb; id_mem_r_en = ld; id_dest = 4'(d); branch_taken = br; mem_ready = mr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    idle();
    repeat (2) tick();
    rst = 1'b1;

    // Reset state
    at_neg();
    cmp("rst_fwd_a", 0, int'(f_fa), 0);
    cmp("rst_stall_cnt", 0, int'(f_sc), 0);
    cmp("rst_freeze", 0, int'(f_fr), 0);
    tick();

    // Load-use with forwarding: one bubble, then forward from slot 2
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0, 1);
    at_neg(); tick();
    drive(1, 1, 3, 0, 0, 1, 0, 4, 0, 1);
    at_neg();
    cmp("lu_freeze", 0, int'(f_fr), 1);
    cmp("lu_bubble", 0, int'(f_bu), 1);
    tick(); at_neg();
    cmp("lu_release", 0, int'(f_fr), 0);
    tick(); idle(); at_neg();
    cmp("lu_fwd_a", 0, int'(f_fa), 2);
    cmp("lu_stall_cnt", 0, int'(f_sc), 1);
    tick();

    // ALU forwarding distance 1 and 2 on src2
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 5, 0, 1);
    at_neg(); tick();
    drive(1, 0, 0, 1, 5, 1, 0, 6, 0, 1);
    at_neg();
    cmp("alu_nostall", 0, int'(f_fr), 0);
    tick();
    drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 1);
    at_neg();
    cmp("alu_fwd_b1", 0, int'(f_fb), 1);
    tick(); idle(); at_neg();
    cmp("alu_fwd_b2", 0, int'(f_fb), 2);
    tick();

    // No forwarding: dependency on EXE stalls STAGES-1 cycles
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 2, 0, 1);
    at_neg(); tick();
    drive(1, 1, 2, 0, 0, 1, 0, 7, 0, 1);
    at_neg();
    cmp("nf_stall1", 2, int'(s_fr), 1);
    tick(); at_neg();
    cmp("nf_stall2", 2, int'(s_fr), 1);
    tick(); at_neg();
    cmp("nf_release", 2, int'(s_fr), 0);
    cmp("nf_stall_cnt", 2, int'(s_sc), 2);
    cmp("nf_s4_stall3", 1, int'(n_fr), 1);
    tick(); idle(); at_neg();
    cmp("nf_fwd_a", 2, int'(s_fa), 0);
    tick();

    // Branch beats load-use
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0, 1);
    at_neg(); tick();
    drive(1, 1, 3, 0, 0, 1, 0, 4, 1, 1);
    at_neg();
    cmp("br_flush", 0, int'(f_fl), 1);
    cmp("br_freeze", 0, int'(f_fr), 0);
    cmp("br_bubble", 0, int'(f_bu), 0);
    tick();
    drive(1, 1, 3, 0, 0, 1, 0, 4, 0, 1);
    at_neg();
    cmp("br_exe_empty", 0, int'(f_fr), 0);
    cmp("br_flush_cnt", 0, int'(f_fc), 1);
    cmp("br_stall_cnt", 0, int'(f_sc), 0);
    tick();

    // Memory wait over a load-use hazard
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 3, 0, 1);
    at_neg(); tick();
    drive(1, 1, 3, 0, 0, 1, 0, 4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      cmp("mw_stall_all", 0, int'(f_sa), 1);
      cmp("mw_freeze", 0, int'(f_fr), 1);
      cmp("mw_bubble", 0, int'(f_bu), 0);
      tick();
    end
    mem_ready = 1'b1;
    at_neg();
    cmp("mw_bubble_after", 0, int'(f_bu), 1);
    cmp("mw_cnt_held", 0, int'(f_sc), 0);
    tick(); at_neg();
    cmp("mw_release", 0, int'(f_fr), 0);
    cmp("mw_stall_cnt", 0, int'(f_sc), 1);
    tick(); idle(); at_neg();
    cmp("mw_fwd_a", 0, int'(f_fa), 2);
    tick();

    // Counter saturation, then asynchronous reset mid-cycle
    do_reset();
    drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 1);
    repeat (40) begin at_neg(); tick(); end
    at_neg();
    cmp("sat_s3", 2, int'(s_sc), 15);
    cmp("sat_s4", 1, int'(n_sc), 15);
    cmp("sat_fwd_a", 0, int'(f_fa), 1);
    #1;
    rst = 1'b0;
    #1;
    cmp("ar_fwd_a", 0, int'(f_fa), 0);
    cmp("ar_cnt_s3", 2, int'(s_sc), 0);
    cmp("ar_cnt_s4", 1, int'(n_sc), 0);
    cmp("ar_freeze", 2, int'(s_fr), 0);
    tick();
    rst = 1'b1;

    // Randomized traffic, biased towards a few registers to create hazards
    for (int k = 0; k < 3000; k++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      id_src1_en   = ($urandom_range(0, 3) != 0);
      id_two_src   = ($urandom_range(0, 1) != 0);
      id_wb_en     = ($urandom_range(0, 3) != 0);
      id_mem_r_en  = ($urandom_range(0, 2) == 0);
      id_src1      = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      id_src2      = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      id_dest      = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      branch_taken = ($urandom_range(0, 9) == 0);
      mem_ready    = ($urandom_range(0, 19) > 2);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      tick();
    end
    rst = 1'b1;
    idle();
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline-control block for the ARM core. It tracks the destination registers of instructions in flight from EXE to the end of the pipeline and decides per cycle whether the instruction in ID may advance. It drives the freeze, flush and bubble controls of the IF, IF/ID and ID/EXE stages, and produces registered forwarding selects for the EXE operand muxes. Depth, register-address width and forwarding mode are parameters, and global stall on data-memory wait and performance counters are built in.

## Interface
- `REG_AW`, 4: register-address width.
- `STAGES`, 3: number of tracked in-flight stages after ID. Entry 0 = EXE, entry STAGES-1 = WB. Legal range 2..8.
- `FWD_EN`, 1: 1 = forwarding mode; 0 = stall on every RAW match.
- `CNT_W`, 16: width of the performance counters.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1` in REG_AW: Rn address.
- `id_src1_en` in 1: Rn is read.
- `id_src2` in REG_AW: Rm/Rd address.
- `id_two_src` in 1: src2 is read.
- `id_dest` in REG_AW: destination of the ID instruction.
- `id_wb_en` in 1: the ID instruction writes back.
- `id_mem_r_en` in 1: the ID instruction is a load.
- `branch_taken` in 1: the branch in EXE is taken this cycle.
- `mem_ready` in 1: data memory done. 0 = whole pipeline waits.
- `freeze` out 1: hold PC and IF/ID.
- `bubble` out 1: load a NOP into ID/EXE.
- `flush` out 1: clear IF/ID and ID/EXE.
- `stall_all` out 1: hold every stage register (= !mem_ready).
- `fwd_sel_a`, `fwd_sel_b` out $clog2(STAGES): registered operand selects for the instruction in EXE. 0 = register file; k = result of entry k.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- Scoreboard: STAGES entries of {v, wb, ld, dest}.
- Match: a source matches entry i when the source is enabled, `id_valid` is set, entry i has v=1 and wb=1, and dest equals the source address.
- Hazard with FWD_EN=0: any source matches any entry 0..STAGES-2. Entry STAGES-1 writes in the same cycle; the register file is write-first.
- Hazard with FWD_EN=1: any source matches entry 0 and entry 0 has ld=1 (load-use).
- Priority per cycle, highest first:
  - `!mem_ready`: stall_all=1, freeze=1, flush=0, bubble=0. Scoreboard, fwd selects and counters hold.
  - `branch_taken`: flush=1, freeze=0, bubble=0. The scoreboard shifts and entry 0 gets a bubble; any hazard is ignored. flush_cnt+1.
  - hazard: freeze=1, bubble=1. The scoreboard shifts and entry 0 gets a bubble. stall_cnt+1.
  - otherwise: all controls 0. The scoreboard shifts and entry 0 gets {id_valid, id_wb_en, id_mem_r_en, id_dest}.
- Shift: entry i+1 gets entry i. The old entry STAGES-1 is dropped.
- Forward select (FWD_EN=1, advancing cycle only): for each source, take the youngest matching entry j in 0..STAGES-2 and register fwd_sel = j+1; no match registers 0.
- Forward select on bubble/flush cycles, and always when FWD_EN=0: register 0.
- Counters saturate at all-ones and never wrap.
- Combinational outputs: freeze, bubble, flush, stall_all. Registered outputs: fwd_sel_a/b, entries, counters.

## Timing
- Reset (rst=0, asynchronous): all entries v=0, fwd_sel=0, counters=0. Combinational outputs then follow the inputs, with no hazard possible.
- Hazard decision: zero latency, same cycle as the ID contents.
- Load-use with FWD_EN=1: exactly one bubble cycle.
- Without forwarding: a dependency on entry 0 stalls STAGES-1 cycles.
- Branch and hazard in the same cycle: flush only, the stalled instruction is discarded, and stall_cnt does not increment.
- mem_ready low during a hazard: stall_all wins and the hazard is re-evaluated after release.
- Reset asserted mid-stall: all state clears immediately and freeze drops once the inputs no longer create a hazard.
- Dest and source both 0: a normal match; no special register.

## Test plan
- FWD_EN=1, STAGES=3: EXE holds load r3, ID reads r3 → freeze=bubble=1 for 1 cycle, then fwd_sel_a=2 next cycle, stall_cnt=1.
- FWD_EN=1: ALU writes r5, next instruction reads r5 as src2 → no stall, fwd_sel_b=1. Reading r5 two instructions later → fwd_sel_b=2.
- FWD_EN=0, STAGES=3: ID reads r2 right after a write of r2 → freeze high for 2 cycles, then release with fwd_sel=0.
- branch_taken together with a load-use hazard → flush=1, freeze=0, flush_cnt=1, stall_cnt=0, entry 0 invalid.
- mem_ready=0 for 4 cycles during a load-use hazard → stall_all=1 and all state frozen. After release, one bubble.
- CNT_W=4: force 20 hazards → stall_cnt=15. Assert rst asynchronously mid-clock → counters=0 and fwd_sel=0 immediately.
